// File: rtl/count_frame_serializer_pkg.sv
// Shared definitions for count_frame_serializer: FSM state encoding and header defaults.
// Optional checksum byte is enabled by defining FRAME_CSUM_EN.
package count_frame_serializer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2,
      ST_CSUM = 2'd3
   } state_t;

   localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

   function automatic logic [7:0] header_byte(input logic [7:0] base, input logic chan);
      return base | {7'b0, chan};
   endfunction

endpackage

// File: rtl/count_frame_serializer_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones; asynchronous active-low clear.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/count_frame_serializer.sv
// count_frame_serializer: snapshots one of two counters on Capture and streams header + bytes (MSB first)
// over a valid/ready link. Define FRAME_CSUM_EN to append an XOR checksum byte after the data bytes.
module count_frame_serializer
   import count_frame_serializer_pkg::*;
#(
   parameter int         DATA_W   = 64,
   parameter logic [7:0] HDR_BASE = HDR_BASE_DEFAULT,
   parameter int         DROP_W   = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [DATA_W-1:0] In0,
   input  logic [DATA_W-1:0] In1,
   input  logic              Sel,
   input  logic              Capture,
   output logic [7:0]        Dout,
   output logic              Dvalid,
   input  logic              Dready,
   output logic              Busy,
   output logic [DROP_W-1:0] DropCnt,
   output logic [1:0]        o_dbg_state
);

   localparam int NBYTES = DATA_W / 8;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   // Link contract: a byte moves on a rising edge where Dvalid & Dready; while Dvalid=1 and Dready=0
   // the byte, state and index stay put, and Dvalid only falls after the last byte of a frame moves.
   state_t                    r_state, w_state_nxt;
   logic [IDX_W-1:0]          r_idx, w_idx_nxt;
   logic [NBYTES-1:0][7:0]    r_snap, w_snap_nxt;
   logic [7:0]                r_dout, w_dout_nxt;
   logic                      r_dvalid, w_dvalid_nxt;
   logic                      r_busy;
   logic                      w_xfer;
   logic                      w_drop_inc;
   logic [IDX_W-1:0]          w_pick_idx;
   logic [7:0]                w_pick_byte;
   logic [7:0]                w_hdr;
`ifdef FRAME_CSUM_EN
   logic [7:0]                r_csum, w_csum_nxt;
`endif

   assign w_xfer     = r_dvalid & Dready;
   assign w_drop_inc = Capture & (r_state != ST_IDLE);
   assign w_hdr      = header_byte(HDR_BASE, Sel);

   // Byte k of the frame body lives at byte lane NBYTES-1-k of the frozen snapshot.
   assign w_pick_idx  = (r_state == ST_HDR) ? '0 : r_idx + IDX_W'(1);
   assign w_pick_byte = r_snap[LAST_IDX - w_pick_idx];

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_snap_nxt   = r_snap;
      w_dout_nxt   = r_dout;
      w_dvalid_nxt = r_dvalid;
`ifdef FRAME_CSUM_EN
      w_csum_nxt   = r_csum;
`endif
      case (r_state)
         ST_IDLE: begin
            if (Capture) begin
               w_state_nxt  = ST_HDR;
               w_snap_nxt   = Sel ? In1 : In0;
               w_dout_nxt   = w_hdr;
               w_dvalid_nxt = 1'b1;
`ifdef FRAME_CSUM_EN
               w_csum_nxt   = w_hdr;
`endif
            end
         end
         ST_HDR: begin
            if (w_xfer) begin
               w_state_nxt = ST_DATA;
               w_idx_nxt   = '0;
               w_dout_nxt  = w_pick_byte;
`ifdef FRAME_CSUM_EN
               w_csum_nxt  = r_csum ^ w_pick_byte;
`endif
            end
         end
         ST_DATA: begin
            if (w_xfer) begin
               if (r_idx == LAST_IDX) begin
`ifdef FRAME_CSUM_EN
                  w_state_nxt  = ST_CSUM;
                  w_dout_nxt   = r_csum;
`else
                  w_state_nxt  = ST_IDLE;
                  w_dout_nxt   = 8'h00;
                  w_dvalid_nxt = 1'b0;
`endif
               end else begin
                  w_idx_nxt  = r_idx + IDX_W'(1);
                  w_dout_nxt = w_pick_byte;
`ifdef FRAME_CSUM_EN
                  w_csum_nxt = r_csum ^ w_pick_byte;
`endif
               end
            end
         end
`ifdef FRAME_CSUM_EN
         ST_CSUM: begin
            if (w_xfer) begin
               w_state_nxt  = ST_IDLE;
               w_dout_nxt   = 8'h00;
               w_dvalid_nxt = 1'b0;
            end
         end
`endif
         default: begin
            w_state_nxt  = ST_IDLE;
            w_dout_nxt   = 8'h00;
            w_dvalid_nxt = 1'b0;
         end
      endcase
   end

   // Reset is expected to be released synchronously to Clk by its source.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_snap   <= '0;
         r_dout   <= 8'h00;
         r_dvalid <= 1'b0;
         r_busy   <= 1'b0;
`ifdef FRAME_CSUM_EN
         r_csum   <= 8'h00;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_snap   <= w_snap_nxt;
         r_dout   <= w_dout_nxt;
         r_dvalid <= w_dvalid_nxt;
         r_busy   <= (w_state_nxt != ST_IDLE);
`ifdef FRAME_CSUM_EN
         r_csum   <= w_csum_nxt;
`endif
      end
   end

   sat_counter #(.W(DROP_W)) u_drop_cnt (
      .i_clk   (Clk),
      .i_rst_n (Reset),
      .i_inc   (w_drop_inc),
      .o_count (DropCnt)
   );

   assign Dout        = r_dout;
   assign Dvalid      = r_dvalid;
   assign Busy        = r_busy;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_count_frame_serializer.sv
// Bench for count_frame_serializer: reference frame model feeds an expected-byte queue drained by a monitor.
// Honours FRAME_CSUM_EN the same way as the design (checksum byte appended to expected frames).
module tb_count_frame_serializer;

   localparam int DATA_W    = 64;
   localparam int NB        = DATA_W / 8;
   localparam int DROP_W    = 8;
   localparam int DROP_MAX  = (1 << DROP_W) - 1;
`ifdef FRAME_CSUM_EN
   localparam int FRAME_LEN = NB + 2;
`else
   localparam int FRAME_LEN = NB + 1;
`endif

   logic              clk;
   logic              rst_n;
   logic [DATA_W-1:0] in0, in1;
   logic              sel, capture, dready;
   logic [7:0]        dout;
   logic              dvalid, busy;
   logic [DROP_W-1:0] drop_cnt;
   logic [1:0]        dbg_state;

   logic [7:0] exp_q[$];
   int         left;
   int         exp_drop;
   logic       prev_stall;
   logic [7:0] prev_dout;
   int         n_tests;
   int         n_fail;

   count_frame_serializer #(.DATA_W(DATA_W), .HDR_BASE(8'hA0), .DROP_W(DROP_W)) dut (
      .Clk         (clk),
      .Reset       (rst_n),
      .In0         (in0),
      .In1         (in1),
      .Sel         (sel),
      .Capture     (capture),
      .Dout        (dout),
      .Dvalid      (dvalid),
      .Dready      (dready),
      .Busy        (busy),
      .DropCnt     (drop_cnt),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model + monitor ----------------
   // Sampled mid-cycle: values seen here are what the next rising edge will act on.
   always @(negedge clk) begin : scoreboard
      logic       busy_before;
      logic [7:0] b, cs;
      logic [63:0] snap;
      if (!rst_n) begin
         exp_q.delete();
         left       = 0;
         exp_drop   = 0;
         prev_stall = 1'b0;
      end else begin
         check("busy", busy, 64'(left != 0));
         check("dvalid", dvalid, 64'(left != 0));
         check("dropcnt", drop_cnt, 64'(exp_drop));
         if (prev_stall) check("stall_hold", dout, prev_dout);
         busy_before = (left != 0);
         if (dvalid && dready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL byte_unexpected: got %0h expected no byte at %0t", dout, $time);
            end else begin
               b = exp_q.pop_front();
               check("byte", dout, b);
            end
            if (left > 0) left--;
         end
         prev_stall = dvalid && !dready;
         prev_dout  = dout;
         if (capture) begin
            if (busy_before) begin
               if (exp_drop < DROP_MAX) exp_drop++;
            end else begin
               snap = sel ? in1 : in0;
               b    = 8'hA0 + (sel ? 8'd1 : 8'd0);
               exp_q.push_back(b);
               cs   = b;
               for (int i = 0; i < NB; i++) begin
                  b  = 8'((snap >> (8 * (NB - 1 - i))) & 64'hFF);
                  exp_q.push_back(b);
                  cs = cs ^ b;
               end
`ifdef FRAME_CSUM_EN
               exp_q.push_back(cs);
`endif
               left = FRAME_LEN;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic do_capture(input logic s);
      sel     = s;
      capture = 1'b1;
      step();
      capture = 1'b0;
      sel     = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (left != 0 && n < 1000) begin
         step();
         n++;
      end
      step();
      check("idle_in_budget", busy, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      in0     = '0;
      in1     = '0;
      sel     = 1'b0;
      capture = 1'b0;
      dready  = 1'b1;
      #1;
      check("reset_dvalid", dvalid, 0);
      check("reset_dout", dout, 0);
      do_reset();

      // 1: idle after reset
      for (int c = 0; c < 20; c++) begin
         step();
         check("idle_dout", dout, 0);
      end

      // 2: channel 0, sink always ready
      in0 = 64'h0123_4567_89AB_CDEF;
      do_capture(1'b0);
      check("first_byte_hdr", dout, 8'hA0);
      wait_idle();

      // 3: channel 1 with sink toggling every two cycles
      in1 = 64'hFFFF_0000_FFFF_0001;
      do_capture(1'b1);
      check("ch1_hdr", dout, 8'hA1);
      for (int c = 0; c < 40; c++) begin
         dready = ((c / 2) % 2) == 0 ? 1'b0 : 1'b1;
         step();
      end
      dready = 1'b1;
      wait_idle();

      // 4: captures 3 cycles in and on the final-transfer edge, then saturation
      do_reset();
      in0 = {$urandom(), $urandom()};
      do_capture(1'b0);
      step();
      step();
      capture = 1'b1;
      step();
      capture = 1'b0;
      repeat (FRAME_LEN - 4) step();
      capture = 1'b1;
      step();
      capture = 1'b0;
      wait_idle();
      check("drop_two", drop_cnt, 2);
      do_capture(1'b1);
      dready = 1'b0;
      for (int c = 0; c < 300; c++) begin
         capture = 1'b1;
         step();
      end
      capture = 1'b0;
      check("drop_saturated", drop_cnt, 8'hFF);
      dready = 1'b1;
      wait_idle();

      // 5: inputs churn after capture
      in0 = {$urandom(), $urandom()};
      do_capture(1'b0);
      for (int c = 0; c < FRAME_LEN + 2; c++) begin
         in0 = {$urandom(), $urandom()};
         in1 = {$urandom(), $urandom()};
         step();
      end
      wait_idle();

      // 6: reset while data byte 4 is presented
      in0 = {$urandom(), $urandom()};
      do_capture(1'b0);
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      check("rst_mid_dvalid", dvalid, 0);
      check("rst_mid_busy", busy, 0);
      step();
      step();
      rst_n = 1'b1;
      step();
      in1 = {$urandom(), $urandom()};
      do_capture(1'b1);
      check("post_rst_hdr", dout, 8'hA1);
      wait_idle();

      // 7: random traffic
      for (int c = 0; c < 600; c++) begin
         capture = ($urandom_range(0, 9) == 0);
         sel     = 1'($urandom_range(0, 1));
         in0     = {$urandom(), $urandom()};
         in1     = {$urandom(), $urandom()};
         dready  = ($urandom_range(0, 3) != 0);
         step();
      end
      capture = 1'b0;
      dready  = 1'b1;
      wait_idle();

      check("queue_drained", 64'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
